// File: rtl/e_muldiv.sv
// E-stage multiply/divide unit for the 5-stage MIPS pipeline.
// Owns HI/LO. Results are computed at the accept edge and committed after a fixed latency.
module e_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [2:0]  MDUOP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HILO_sel,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] HILO_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    mdu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      hi, hi_next;
    logic [31:0]      lo, lo_next;
    logic [31:0]      temp_hi, temp_hi_next;
    logic [31:0]      temp_lo, temp_lo_next;
    logic             div_zero, div_zero_next;

    mdu_op_e op;
    logic    accept;

    assign op     = mdu_op_e'(MDUOP);
    assign accept = (state == ST_IDLE) && !Req;

    // Multiply: extend both operands to 64 bits; the low 64 bits of the product are correct for both signednesses.
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, product;

    assign mul_signed = (op == OP_MULT);
    assign mul_a      = {{32{mul_signed & A[31]}}, A};
    assign mul_b      = {{32{mul_signed & B[31]}}, B};
    assign product    = mul_a * mul_b;

    // Divide on magnitudes and re-apply signs; this also gives 0x80000000/-1 -> LO=0x80000000, HI=0.
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quotient, remainder;

    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed & A[31];
    assign b_neg      = div_signed & B[31];
    assign a_mag      = a_neg ? (~A + 32'd1) : A;
    assign b_mag      = b_neg ? (~B + 32'd1) : B;
    assign divisor    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / divisor;
    assign r_mag      = a_mag % divisor;
    assign quotient   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign remainder  = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            temp_hi  <= '0;
            temp_lo  <= '0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            hi       <= hi_next;
            lo       <= lo_next;
            temp_hi  <= temp_hi_next;
            temp_lo  <= temp_lo_next;
            div_zero <= div_zero_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        hi_next       = hi;
        lo_next       = lo;
        temp_hi_next  = temp_hi;
        temp_lo_next  = temp_lo;
        div_zero_next = div_zero;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            temp_hi_next  = product[63:32];
                            temp_lo_next  = product[31:0];
                            div_zero_next = 1'b0;
                            cnt_next      = CNT_W'(MULT_CYCLES);
                            state_next    = ST_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            temp_hi_next  = remainder;
                            temp_lo_next  = quotient;
                            div_zero_next = (B == 32'd0);
                            cnt_next      = CNT_W'(DIV_CYCLES);
                            state_next    = ST_BUSY;
                        end
                        OP_MTHI: hi_next = A;
                        OP_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    if (!div_zero) begin
                        hi_next = temp_hi;
                        lo_next = temp_lo;
                    end
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign start    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign busy     = (state == ST_BUSY);
    assign HI_out   = hi;
    assign LO_out   = lo;
    assign HILO_out = HILO_sel ? hi : lo;

endmodule
